spi_reg_slave_n: RTL and testbench
==================================

SPI_REG_SLAVE_N -- requirements
Module: spi_reg_slave_n

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7: register address bits per frame.
REQ-002 The block SHALL have parameter DATA_W, default 16: data bits per frame and register width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, legal range 2..2**ADDR_W: number of implemented registers.
REQ-004 The block SHALL have parameter ID_VALUE, default 16'hD1C5, truncated to DATA_W: fixed read-only content of register 0.
REQ-005 The block SHALL have port ACLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port ARESET, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port SPI_SCK, input, 1 bit: asynchronous SPI clock, mode 0 (idle low, sample on rising edge).
REQ-008 The block SHALL have port SPI_CSN, input, 1 bit: asynchronous active-low chip select.
REQ-009 The block SHALL have port SPI_SDI, input, 1 bit: asynchronous serial data in, MSB first.
REQ-010 The block SHALL have port SPI_SDO, output, 1 bit: serial read data, MSB first.
REQ-011 The block SHALL have port SPI_SDO_OE, output, 1 bit: drive enable for a shared 3-wire data pin.
REQ-012 The block SHALL have port REG_Q, output, NUM_REGS*DATA_W bits: flattened register contents, register k at bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port WR_STB, output, 1 bit: one-ACLK pulse on each committed write.
REQ-014 The block SHALL have port WR_ADDR, output, ADDR_W bits: address of the last committed write.
REQ-015 The block SHALL have port ERR_CNT, output, 8 bits: saturating count of aborted or out-of-range frames.

Function
REQ-016 SPI_SCK, SPI_CSN and SPI_SDI SHALL each pass through a 2-flop synchronizer; SCK edges are detected from a third flop; supported SCK frequency is at most ACLK/8.
REQ-017 The frame format SHALL be 1 R/W bit (1 = read), then ADDR_W address bits, then DATA_W data bits, giving 1+ADDR_W+DATA_W bits, sampled on synchronized SCK rising edges while CSN is low.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, DATA, DONE; a synchronized CSN falling edge moves IDLE->CMD with the bit counter cleared.
REQ-019 CMD SHALL latch R/W on the first rising edge and go to ADDR; ADDR SHALL go to DATA after ADDR_W bits; DATA SHALL go to DONE after DATA_W bits.
REQ-020 DONE SHALL ignore further SCK edges and return to IDLE when synchronized CSN goes high.
REQ-021 A write SHALL be committed in the ACLK cycle after the final data bit is sampled: REG_Q[addr] updates, WR_STB=1 for exactly one cycle, WR_ADDR=addr.
REQ-022 Writes to address 0 SHALL NOT change register 0, but SHALL still pulse WR_STB.
REQ-023 For a read, the addressed register SHALL be loaded into the shift-out register when the last address bit is sampled; SPI_SDO_OE=1 from then until CSN goes high.
REQ-024 During a read, SPI_SDO SHALL present the data MSB before the next SCK rising edge and advance one bit on each synchronized SCK falling edge.
REQ-025 An address >= NUM_REGS SHALL cause a write to be discarded with no WR_STB, SHALL make a read return all zeros, and SHALL increment ERR_CNT once at DONE.
REQ-026 If CSN rises in CMD, ADDR or DATA, the FSM SHALL abort to IDLE with no commit and no WR_STB, and SHALL increment ERR_CNT.
REQ-027 A CSN rise in IDLE without any SCK edge SHALL NOT count as an error.
REQ-028 ERR_CNT SHALL saturate at 8'hFF.
REQ-029 When SPI_SDO_OE=0, SPI_SDO SHALL be 0.

Reset
REQ-030 ARESET=1 at an ACLK rising edge SHALL force the following: FSM to IDLE, counters and synchronizers to idle values (SCK=0, CSN=1), REG_Q registers 1..NUM_REGS-1 to 0, register 0 to ID_VALUE, WR_STB=0, WR_ADDR=0, ERR_CNT=0, SPI_SDO=0, SPI_SDO_OE=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame without a commit; a frame whose CSN falling edge occurs while ARESET=1 SHALL be ignored until CSN goes high again.

Verification
REQ-032 Reset then read address 0 (defaults) -> SDO shifts 16'hD1C5, SDO_OE high for the 16 data bits, ERR_CNT=0.
REQ-033 Write 16'hA55A to address 3, then read address 3 -> exactly one WR_STB with WR_ADDR=3, REG_Q[63:48]=16'hA55A, read returns 16'hA55A.
REQ-034 Write to address 20 with NUM_REGS=16 -> no WR_STB, REG_Q unchanged, ERR_CNT=1; a read of address 20 returns 16'h0000 and ERR_CNT=2.
REQ-035 Write frame with CSN raised after 10 data bits -> no WR_STB, target register unchanged, ERR_CNT increments by 1; the next full frame completes correctly.
REQ-036 ARESET pulsed during the DATA state of a write to address 5 -> REG_Q all zero except register 0 (ID_VALUE), no WR_STB; a following write to address 5 succeeds.
REQ-037 Parameter sweep with ADDR_W=4, DATA_W=32, NUM_REGS=8: a write of 32'hDEADBEEF to address 7, then a read, -> read returns 32'hDEADBEEF; 300 aborted frames -> ERR_CNT=8'hFF.

Source files
------------

// File: rtl/spi_reg_slave_n.sv
// SPI mode-0 register slave: frames of R/W bit, address and data, MSB first,
// decoded into a small register file. SPI pins are synchronized into ACLK.
module spi_reg_slave_n #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hD1C5
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         SPI_SCK,
    input  logic                         SPI_CSN,
    input  logic                         SPI_SDI,
    output logic                         SPI_SDO,
    output logic                         SPI_SDO_OE,
    output logic [NUM_REGS*DATA_W-1:0]   REG_Q,
    output logic                         WR_STB,
    output logic [ADDR_W-1:0]            WR_ADDR,
    output logic [7:0]                   ERR_CNT
);

    // state | meaning
    // IDLE  | waiting for a CSN fall (only once CSN has been seen high after reset)
    // CMD   | selected, waiting for the R/W bit
    // ADDR  | shifting in address bits
    // DATA  | shifting in write data / shifting out read data
    // DONE  | frame complete, SCK ignored until CSN goes high
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic sck_m, sck_s, sck_d;
    logic csn_m, csn_s, csn_d;
    logic sdi_m, sdi_s;
    logic [1:0] settle_cnt;
    logic armed;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sck_m      <= 1'b0;
            sck_s      <= 1'b0;
            sck_d      <= 1'b0;
            csn_m      <= 1'b1;
            csn_s      <= 1'b1;
            csn_d      <= 1'b1;
            sdi_m      <= 1'b0;
            sdi_s      <= 1'b0;
            settle_cnt <= 2'd2;
            armed      <= 1'b0;
        end else begin
            sck_m <= SPI_SCK;
            sck_s <= sck_m;
            sck_d <= sck_s;
            csn_m <= SPI_CSN;
            csn_s <= csn_m;
            csn_d <= csn_s;
            sdi_m <= SPI_SDI;
            sdi_s <= sdi_m;
            if (settle_cnt != 2'd0)
                settle_cnt <= settle_cnt - 2'd1;
            // a frame already selected during reset must end before a new one starts
            if (settle_cnt == 2'd0 && csn_s && csn_d)
                armed <= 1'b1;
        end
    end

    logic sck_rise, sck_fall, csn_fall;
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_fall = ~csn_s & csn_d;

    state_t              state;
    logic                rw;
    logic                addr_ok;
    logic [ADDR_W-1:0]   addr_sh;
    logic [DATA_W-1:0]   data_sh;
    logic [DATA_W-1:0]   sdo_sh;
    logic                sdo_oe;
    logic [CNT_W-1:0]    bit_left;
    logic                wr_stb;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          err_cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W-1:0]   addr_next;
    logic [DATA_W-1:0]   data_next;
    logic                addr_in_range;
    logic [DATA_W-1:0]   rd_word;
    logic [7:0]          err_next;

    always_comb begin
        addr_next     = ADDR_W'({addr_sh, sdi_s});
        data_next     = DATA_W'({data_sh, sdi_s});
        addr_in_range = ({1'b0, addr_next} < (ADDR_W+1)'(NUM_REGS));
        err_next      = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
        rd_word       = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (addr_next == ADDR_W'(k))
                rd_word = regs[k];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            rw       <= 1'b0;
            addr_ok  <= 1'b0;
            addr_sh  <= '0;
            data_sh  <= '0;
            sdo_sh   <= '0;
            sdo_oe   <= 1'b0;
            bit_left <= '0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            err_cnt  <= '0;
            regs[0]  <= ID_VALUE;
            for (int k = 1; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && csn_fall) begin
                        state    <= CMD;
                        bit_left <= '0;
                        addr_sh  <= '0;
                        data_sh  <= '0;
                    end
                end
                CMD: begin
                    // a select pulse with no SCK edge is not an error
                    if (csn_s)
                        state <= IDLE;
                    else if (sck_rise) begin
                        rw       <= sdi_s;
                        bit_left <= CNT_W'(ADDR_W - 1);
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (csn_s) begin
                        state   <= IDLE;
                        err_cnt <= err_next;
                    end else if (sck_rise) begin
                        addr_sh <= addr_next;
                        if (bit_left == '0) begin
                            state    <= DATA;
                            bit_left <= CNT_W'(DATA_W - 1);
                            addr_ok  <= addr_in_range;
                            if (rw) begin
                                sdo_sh <= rd_word;
                                sdo_oe <= 1'b1;
                            end
                        end else begin
                            bit_left <= bit_left - 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (csn_s) begin
                        state   <= IDLE;
                        err_cnt <= err_next;
                        sdo_oe  <= 1'b0;
                        sdo_sh  <= '0;
                    end else if (sck_rise) begin
                        data_sh <= data_next;
                        if (bit_left == '0) begin
                            state <= DONE;
                            if (!addr_ok)
                                err_cnt <= err_next;
                            else if (!rw) begin
                                wr_stb  <= 1'b1;
                                wr_addr <= addr_sh;
                                for (int k = 1; k < NUM_REGS; k++)
                                    if (addr_sh == ADDR_W'(k))
                                        regs[k] <= data_next;
                            end
                        end else begin
                            bit_left <= bit_left - 1'b1;
                        end
                    end else if (sck_fall && bit_left != CNT_W'(DATA_W - 1)) begin
                        // MSB is already presented; shift only after a data bit was sampled
                        sdo_sh <= sdo_sh << 1;
                    end
                end
                DONE: begin
                    if (csn_s) begin
                        state  <= IDLE;
                        sdo_oe <= 1'b0;
                        sdo_sh <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SPI_SDO    = sdo_oe & sdo_sh[DATA_W-1];
    assign SPI_SDO_OE = sdo_oe;
    assign WR_STB     = wr_stb;
    assign WR_ADDR    = wr_addr;
    assign ERR_CNT    = err_cnt;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign REG_Q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_slave_n.sv
// Directed bench for spi_reg_slave_n: default instance plus a 4/32/8 instance,
// bit-banged SPI master, register model and read-data scoreboard.
module tb_spi_reg_slave_n;

    localparam int HALF = 5;

    logic ACLK;
    logic ARESET;
    logic sck0, csn0, sdi0, sck1, csn1, sdi1;
    logic sdo0, oe0, sdo1, oe1;
    logic wr_stb0, wr_stb1;
    logic [6:0] wr_addr0;
    logic [3:0] wr_addr1;
    logic [7:0] err0, err1;
    logic [255:0] reg_q0, reg_q1;

    spi_reg_slave_n u_dut0 (
        .ACLK(ACLK), .ARESET(ARESET),
        .SPI_SCK(sck0), .SPI_CSN(csn0), .SPI_SDI(sdi0),
        .SPI_SDO(sdo0), .SPI_SDO_OE(oe0),
        .REG_Q(reg_q0), .WR_STB(wr_stb0), .WR_ADDR(wr_addr0), .ERR_CNT(err0)
    );

    spi_reg_slave_n #(.ADDR_W(4), .DATA_W(32), .NUM_REGS(8), .ID_VALUE(32'h0000D1C5)) u_dut1 (
        .ACLK(ACLK), .ARESET(ARESET),
        .SPI_SCK(sck1), .SPI_CSN(csn1), .SPI_SDI(sdi1),
        .SPI_SDO(sdo1), .SPI_SDO_OE(oe1),
        .REG_Q(reg_q1), .WR_STB(wr_stb1), .WR_ADDR(wr_addr1), .ERR_CNT(err1)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;
    int stb0 = 0;
    int stb1 = 0;
    logic [31:0] m [2][16];
    int err_m [2];
    logic [31:0] sb_q [$];

    always @(negedge ACLK) begin
        if (wr_stb0 === 1'b1) stb0++;
        if (wr_stb1 === 1'b1) stb1++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input int d, input logic sck, input logic csn, input logic sdi);
        if (d == 0) begin sck0 = sck; csn0 = csn; sdi0 = sdi; end
        else        begin sck1 = sck; csn1 = csn; sdi1 = sdi; end
    endtask

    function automatic int aw_of(input int d);  return (d == 0) ? 7 : 4;  endfunction
    function automatic int dw_of(input int d);  return (d == 0) ? 16 : 32; endfunction
    function automatic int nr_of(input int d);  return (d == 0) ? 16 : 8;  endfunction
    function automatic logic get_sdo(input int d); return (d == 0) ? sdo0 : sdo1; endfunction
    function automatic logic get_oe(input int d);  return (d == 0) ? oe0 : oe1;   endfunction
    function automatic logic [7:0] get_err(input int d); return (d == 0) ? err0 : err1; endfunction
    function automatic logic [255:0] get_q(input int d); return (d == 0) ? reg_q0 : reg_q1; endfunction
    function automatic int get_stb(input int d); return (d == 0) ? stb0 : stb1; endfunction
    function automatic logic [31:0] get_wa(input int d);
        return (d == 0) ? {25'b0, wr_addr0} : {28'b0, wr_addr1};
    endfunction

    function automatic logic [255:0] flat(input int d);
        logic [255:0] f = '0;
        for (int k = 0; k < nr_of(d); k++)
            if (d == 0) f[k*16 +: 16] = m[0][k][15:0];
            else        f[k*32 +: 32] = m[1][k];
        return f;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) m[d][k] = 32'h0;
            m[d][0] = 32'h0000D1C5;
            err_m[d] = 0;
        end
    endtask

    // abort_at: raise CSN before clocking that bit; reset_at: pulse ARESET before that bit
    task automatic spi_frame(input int d, input bit rw, input int addr, input logic [31:0] data,
                             input int abort_at, input int reset_at,
                             output logic [31:0] rd, output bit oe_ok);
        int aw, dw, total, j;
        logic [31:0] a;
        logic b;
        aw = aw_of(d);
        dw = dw_of(d);
        total = 1 + aw + dw;
        a = addr;
        rd = '0;
        oe_ok = 1'b1;
        drive(d, 0, 0, 0);
        wait_cyc(HALF);
        for (int i = 0; i < total; i++) begin
            if (i == abort_at) break;
            if (i == reset_at) begin
                ARESET = 1'b1;
                wait_cyc(2);
                ARESET = 1'b0;
            end
            if (i == 0)       b = rw;
            else if (i <= aw) b = a[aw - i];
            else              b = data[dw - 1 - (i - 1 - aw)];
            drive(d, 0, 0, b);
            wait_cyc(HALF);
            if (i > aw) begin
                j = i - 1 - aw;
                rd[dw - 1 - j] = get_sdo(d);
                if (rw) oe_ok &= (get_oe(d) === 1'b1);
                else    oe_ok &= (get_oe(d) === 1'b0) && (get_sdo(d) === 1'b0);
            end
            drive(d, 1, 0, b);
            wait_cyc(HALF);
        end
        drive(d, 0, 0, 0);
        wait_cyc(HALF);
        drive(d, 0, 1, 0);
        wait_cyc(8);
    endtask

    task automatic do_write(input int d, input int addr, input logic [31:0] data, input string tag);
        logic [31:0] r;
        bit o;
        int s0;
        bit in_rng;
        s0 = get_stb(d);
        in_rng = (addr < nr_of(d));
        if (in_rng && addr != 0) m[d][addr] = data;
        if (!in_rng) err_m[d] = sat(err_m[d] + 1);
        spi_frame(d, 1'b0, addr, data, -1, -1, r, o);
        check({tag, "_oe"}, o, 1);
        check({tag, "_stb"}, get_stb(d) - s0, in_rng ? 1 : 0);
        if (in_rng) check({tag, "_wa"}, get_wa(d), addr);
        check({tag, "_regq"}, get_q(d), flat(d));
        check({tag, "_err"}, get_err(d), err_m[d]);
    endtask

    task automatic do_read(input int d, input int addr, input string tag);
        logic [31:0] r, e;
        bit o;
        if (addr < nr_of(d)) sb_q.push_back(m[d][addr]);
        else begin
            sb_q.push_back(32'h0);
            err_m[d] = sat(err_m[d] + 1);
        end
        spi_frame(d, 1'b1, addr, 32'h0, -1, -1, r, o);
        check({tag, "_oe"}, o, 1);
        check({tag, "_oe_end"}, {get_oe(d), get_sdo(d)}, 2'b00);
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed no expected entry, expected one queued", tag);
        end else begin
            e = sb_q.pop_front();
            check(tag, r, e);
        end
        check({tag, "_err"}, get_err(d), err_m[d]);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed no end of stimulus, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bit o;
        int s0;

        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        ARESET = 1'b1;
        model_reset();
        wait_cyc(3);
        check("rst_regq0", reg_q0, flat(0));
        check("rst_regq1", reg_q1, flat(1));
        check("rst_outs0", {wr_stb0, wr_addr0, err0, sdo0, oe0}, '0);
        check("rst_outs1", {wr_stb1, wr_addr1, err1, sdo1, oe1}, '0);
        ARESET = 1'b0;
        wait_cyc(10);

        do_read(0, 0, "rd_id");
        do_write(0, 3, 32'h0000A55A, "wr3");
        check("wr3_field", reg_q0[63:48], 16'hA55A);
        do_read(0, 3, "rd3");
        do_write(0, 0, 32'h00001234, "wr0");
        do_read(0, 0, "rd_id2");

        do_write(0, 20, 32'h0000BEEF, "wr20");
        check("wr20_err1", err0, 8'd1);
        do_read(0, 20, "rd20");
        check("rd20_err2", err0, 8'd2);

        s0 = stb0;
        spi_frame(0, 1'b0, 3, 32'h00001111, 1 + 7 + 10, -1, r, o);
        err_m[0] = sat(err_m[0] + 1);
        check("abort_stb", stb0 - s0, 0);
        check("abort_regq", reg_q0, flat(0));
        check("abort_err", err0, err_m[0]);
        do_write(0, 4, 32'h00000F0F, "wr4");
        do_read(0, 4, "rd4");

        drive(0, 0, 0, 0);
        wait_cyc(10);
        drive(0, 0, 1, 0);
        wait_cyc(8);
        check("empty_cs_err", err0, err_m[0]);

        s0 = stb0;
        spi_frame(0, 1'b0, 5, 32'h00007777, -1, 1 + 7 + 6, r, o);
        model_reset();
        check("rst_mid_stb", stb0 - s0, 0);
        check("rst_mid_regq", reg_q0, flat(0));
        check("rst_mid_outs", {wr_addr0, err0, oe0}, '0);
        do_write(0, 5, 32'h00005A5A, "wr5");
        do_read(0, 5, "rd5");

        do_read(1, 0, "p_rd_id");
        do_write(1, 7, 32'hDEADBEEF, "p_wr7");
        do_read(1, 7, "p_rd7");
        do_read(1, 9, "p_rd9");
        for (int i = 0; i < 300; i++) begin
            spi_frame(1, 1'b0, 3, 32'h0, 3, -1, r, o);
            err_m[1] = sat(err_m[1] + 1);
        end
        check("p_err_sat", err1, 8'hFF);
        check("p_err_model", err1, err_m[1]);
        check("p_regq_final", reg_q1, flat(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
